// File: rtl/i2s_frame_arbiter.sv
// Round-robin frame arbiter: merges CN per-channel byte streams into one
// registered output stream, locking the grant for a whole frame or until idle timeout.
module i2s_frame_arbiter #(
   parameter int CN      = 16,
   parameter int ID_W    = 4,
   parameter int TIMEOUT = 256
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [CN-1:0]     s_axis_tvalid,
   input  logic [8*CN-1:0]   s_axis_tdata,
   input  logic [CN-1:0]     s_axis_tlast,
   output logic [CN-1:0]     s_axis_tready,
   output logic              m_axis_tvalid,
   output logic [7:0]        m_axis_tdata,
   output logic              m_axis_tlast,
   output logic [ID_W-1:0]   m_axis_tid,
   input  logic              m_axis_tready,
   input  logic [CN-1:0]     i_enable,
   output logic              o_timeout,
   output logic [ID_W-1:0]   o_timeout_id
);

   localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   typedef enum logic {IDLE, BUSY} state_t;

   state_t            state_q, state_d;
   logic [ID_W-1:0]   last_grant_q, last_grant_d;
   logic [ID_W-1:0]   grant_q, grant_d;
   logic [CNT_W-1:0]  idle_cnt_q, idle_cnt_d;
   logic              m_valid_q, m_valid_d;
   logic [7:0]        m_data_q, m_data_d;
   logic              m_last_q, m_last_d;
   logic [ID_W-1:0]   m_tid_q, m_tid_d;
   logic              timeout_q, timeout_d;
   logic [ID_W-1:0]   timeout_id_q, timeout_id_d;

   logic [CN-1:0]     req;
   logic              out_free;
   logic              grant_valid;
   logic              accept;

   // First requesting channel strictly after 'last', wrapping around.
   function automatic logic [ID_W-1:0] rr_pick(input logic [CN-1:0] r, input logic [ID_W-1:0] last);
      logic [ID_W-1:0] pick;
      logic            found;
      int              idx;
      pick  = last;
      found = 1'b0;
      for (int i = 1; i <= CN; i++) begin
         idx = (int'(last) + i) % CN;
         if (!found && r[idx]) begin
            pick  = ID_W'(idx);
            found = 1'b1;
         end
      end
      return pick;
   endfunction

   assign req         = s_axis_tvalid & i_enable;
   assign out_free    = ~m_valid_q | m_axis_tready;
   assign grant_valid = s_axis_tvalid[grant_q];
   assign accept      = (state_q == BUSY) && grant_valid && out_free;

   always_comb begin
      s_axis_tready = '0;
      if (state_q == BUSY && !rst) begin
         s_axis_tready[grant_q] = out_free;
      end
   end

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      grant_d      = grant_q;
      idle_cnt_d   = idle_cnt_q;
      m_valid_d    = m_valid_q;
      m_data_d     = m_data_q;
      m_last_d     = m_last_q;
      m_tid_d      = m_tid_q;
      timeout_d    = 1'b0;
      timeout_id_d = timeout_id_q;

      if (accept) begin
         m_valid_d = 1'b1;
         m_data_d  = s_axis_tdata[8*grant_q +: 8];
         m_last_d  = s_axis_tlast[grant_q];
         m_tid_d   = grant_q;
      end else if (m_axis_tready) begin
         m_valid_d = 1'b0;
      end

      case (state_q)
         IDLE: begin
            if (|req) begin
               grant_d    = rr_pick(req, last_grant_q);
               idle_cnt_d = '0;
               state_d    = BUSY;
            end
         end
         BUSY: begin
            if (accept) begin
               idle_cnt_d = '0;
               if (s_axis_tlast[grant_q]) begin
                  last_grant_d = grant_q;
                  state_d      = IDLE;
               end
            end else if (!grant_valid) begin
               // Only source silence ages the grant; downstream stalls do not.
               if (idle_cnt_q == CNT_W'(TIMEOUT - 1)) begin
                  timeout_d    = 1'b1;
                  timeout_id_d = grant_q;
                  last_grant_d = grant_q;
                  idle_cnt_d   = '0;
                  state_d      = IDLE;
               end else begin
                  idle_cnt_d = idle_cnt_q + 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         last_grant_q <= ID_W'(CN - 1);
         grant_q      <= '0;
         idle_cnt_q   <= '0;
         m_valid_q    <= 1'b0;
         m_data_q     <= '0;
         m_last_q     <= 1'b0;
         m_tid_q      <= '0;
         timeout_q    <= 1'b0;
         timeout_id_q <= '0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         grant_q      <= grant_d;
         idle_cnt_q   <= idle_cnt_d;
         m_valid_q    <= m_valid_d;
         m_data_q     <= m_data_d;
         m_last_q     <= m_last_d;
         m_tid_q      <= m_tid_d;
         timeout_q    <= timeout_d;
         timeout_id_q <= timeout_id_d;
      end
   end

   assign m_axis_tvalid = m_valid_q;
   assign m_axis_tdata  = m_data_q;
   assign m_axis_tlast  = m_last_q;
   assign m_axis_tid    = m_tid_q;
   assign o_timeout     = timeout_q;
   assign o_timeout_id  = timeout_id_q;

endmodule

// File: tb/tb_i2s_frame_arbiter.sv
// Directed bench for i2s_frame_arbiter: per-channel frame sources, an output
// capture monitor, and hand-computed expectations for each scenario.
module tb_i2s_frame_arbiter;

   localparam int CN      = 16;
   localparam int ID_W    = 4;
   localparam int TIMEOUT = 16;

   logic              clk = 1'b0;
   logic              rst;
   logic [CN-1:0]     s_axis_tvalid;
   logic [8*CN-1:0]   s_axis_tdata;
   logic [CN-1:0]     s_axis_tlast;
   logic [CN-1:0]     s_axis_tready;
   logic              m_axis_tvalid;
   logic [7:0]        m_axis_tdata;
   logic              m_axis_tlast;
   logic [ID_W-1:0]   m_axis_tid;
   logic              m_axis_tready;
   logic [CN-1:0]     i_enable;
   logic              o_timeout;
   logic [ID_W-1:0]   o_timeout_id;

   i2s_frame_arbiter #(.CN(CN), .ID_W(ID_W), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst),
      .s_axis_tvalid(s_axis_tvalid), .s_axis_tdata(s_axis_tdata),
      .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
      .m_axis_tvalid(m_axis_tvalid), .m_axis_tdata(m_axis_tdata),
      .m_axis_tlast(m_axis_tlast), .m_axis_tid(m_axis_tid),
      .m_axis_tready(m_axis_tready), .i_enable(i_enable),
      .o_timeout(o_timeout), .o_timeout_id(o_timeout_id)
   );

   always #5 clk = ~clk;

   // Per-channel source state: bytes still to send, frame length, position, next byte.
   int         bytes_left [CN];
   int         fr_len     [CN];
   int         pos        [CN];
   logic [7:0] nxt        [CN];

   always_comb begin
      s_axis_tvalid = '0;
      s_axis_tdata  = '0;
      s_axis_tlast  = '0;
      for (int c = 0; c < CN; c++) begin
         s_axis_tvalid[c]        = (bytes_left[c] != 0);
         s_axis_tdata[8*c +: 8]  = nxt[c];
         s_axis_tlast[c]         = (pos[c] == fr_len[c] - 1);
      end
   end

   typedef struct {
      int tid;
      int data;
      int last;
      int cyc;
   } beat_t;

   beat_t         cap_q [$];
   logic [CN-1:0] fire_q = '0;
   int            cyc = 0;
   int            to_cnt = 0;
   int            to_id = -1;
   int            hold_err = 0;
   int            stall_err = 0;
   int            stall_seen = 0;
   logic          stall_prev = 1'b0;
   logic [7:0]    h_data;
   logic          h_last;
   logic [ID_W-1:0] h_tid;

   // Monitor: everything sampled on the falling edge, mid-cycle.
   always @(negedge clk) begin
      cyc++;
      fire_q = s_axis_tvalid & s_axis_tready;
      if (!rst) begin
         if (stall_prev && (!m_axis_tvalid || m_axis_tdata != h_data ||
                            m_axis_tlast != h_last || m_axis_tid != h_tid))
            hold_err++;
         if (m_axis_tvalid && !m_axis_tready) begin
            stall_seen++;
            if (s_axis_tready != '0) stall_err++;
         end
         if (m_axis_tvalid && m_axis_tready)
            cap_q.push_back('{int'(m_axis_tid), int'(m_axis_tdata), int'(m_axis_tlast), cyc});
         if (o_timeout) begin
            to_cnt++;
            to_id = int'(o_timeout_id);
         end
      end
      stall_prev = !rst && m_axis_tvalid && !m_axis_tready;
      h_data = m_axis_tdata;
      h_last = m_axis_tlast;
      h_tid  = m_axis_tid;
   end

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic advance();
      for (int c = 0; c < CN; c++) begin
         if (fire_q[c]) begin
            nxt[c] = nxt[c] + 8'd1;
            bytes_left[c] = bytes_left[c] - 1;
            pos[c] = (pos[c] == fr_len[c] - 1) ? 0 : pos[c] + 1;
         end
      end
   endtask

   // Every main-process cycle ends 2 time units after the rising edge.
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
         advance();
         #1;
      end
   endtask

   task automatic load(input int c, input int len, input int n, input int base);
      fr_len[c]     = len;
      bytes_left[c] = n;
      pos[c]        = 0;
      nxt[c]        = 8'(base);
   endtask

   task automatic wait_beats(input string tag, input int b0, input int n, input int budget);
      int w;
      w = 0;
      while (cap_q.size() - b0 < n && w < budget) begin
         tick(1);
         w++;
      end
      check_eq(tag, cap_q.size() - b0, n);
   endtask

   task automatic check_beat(input string tag, input int i, input int tid, input int data, input int last);
      if (i < cap_q.size()) begin
         check_eq({tag, "_tid"},  cap_q[i].tid,  tid);
         check_eq({tag, "_data"}, cap_q[i].data, data);
         check_eq({tag, "_last"}, cap_q[i].last, last);
      end
   endtask

   task automatic wait_ready(input string tag, input int c);
      int w;
      w = 0;
      tick(1);
      while (!s_axis_tready[c] && w < 40) begin
         tick(1);
         w++;
      end
      check_eq(tag, s_axis_tready[c], 1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got no completion, expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int b0;
      int rr_ch [3];
      int rr_base [3];
      int pat [4];
      int w;
      int ch;
      int idx;
      rr_ch   = '{0, 5, 15};
      rr_base = '{'h10, 'h50, 'hF0};
      pat     = '{1, 0, 0, 1};

      for (int c = 0; c < CN; c++) load(c, 1, 0, 0);
      rst = 1'b1;
      m_axis_tready = 1'b1;
      i_enable = '1;

      // Reset state.
      tick(3);
      check_eq("rst_tvalid", m_axis_tvalid, 0);
      check_eq("rst_tdata", m_axis_tdata, 0);
      check_eq("rst_tlast", m_axis_tlast, 0);
      check_eq("rst_tid", m_axis_tid, 0);
      check_eq("rst_s_tready", s_axis_tready, 0);
      check_eq("rst_timeout", o_timeout, 0);
      check_eq("rst_timeout_id", o_timeout_id, 0);
      rst = 1'b0;
      tick(1);

      // Single-channel frame on ch3, one cycle acceptance-to-output.
      load(3, 4, 4, 'hA0);
      wait_ready("t1_grant", 3);
      for (int k = 0; k < 4; k++) begin
         tick(1);
         check_eq("t1_valid", m_axis_tvalid, 1);
         check_eq("t1_data", m_axis_tdata, 'hA0 + k);
         check_eq("t1_tid", m_axis_tid, 3);
         check_eq("t1_last", m_axis_tlast, (k == 3) ? 1 : 0);
      end
      tick(1);
      check_eq("t1_drain", m_axis_tvalid, 0);

      // Round robin after a reset: 0,5,15,0,5,15 with a bubble between frames.
      rst = 1'b1;
      tick(2);
      rst = 1'b0;
      b0 = cap_q.size();
      load(0, 2, 4, 'h10);
      load(5, 2, 4, 'h50);
      load(15, 2, 4, 'hF0);
      wait_beats("t2_count", b0, 12, 200);
      tick(5);
      check_eq("t2_no_extra", cap_q.size() - b0, 12);
      for (int f = 0; f < 6; f++) begin
         for (int b = 0; b < 2; b++) begin
            idx = b0 + 2*f + b;
            check_beat("t2", idx, rr_ch[f % 3], rr_base[f % 3] + 2*(f / 3) + b, b);
            if (idx > b0 && idx < cap_q.size())
               check_eq("t2_gap", cap_q[idx].cyc - cap_q[idx-1].cyc, (b == 0) ? 2 : 1);
         end
      end

      // Backpressure on a ch2 frame with downstream ready 1,0,0,1,...
      b0 = cap_q.size();
      load(2, 4, 4, 'h20);
      w = 0;
      while (cap_q.size() - b0 < 4 && w < 80) begin
         m_axis_tready = pat[w % 4][0];
         tick(1);
         w++;
      end
      m_axis_tready = 1'b1;
      tick(3);
      check_eq("t3_count", cap_q.size() - b0, 4);
      for (int k = 0; k < 4; k++) check_beat("t3", b0 + k, 2, 'h20 + k, (k == 3) ? 1 : 0);
      check_eq("t3_stalls_seen", (stall_seen > 0) ? 1 : 0, 1);
      check_eq("t3_hold", hold_err, 0);
      check_eq("t3_stall_tready", stall_err, 0);
      check_eq("t3_no_timeout", to_cnt, 0);

      // Timeout: ch7 goes silent mid-frame, ch8 waiting, then two ch8 frames.
      b0 = cap_q.size();
      load(7, 4, 1, 'h70);
      load(8, 2, 4, 'h80);
      wait_beats("t4_count", b0, 5, 200);
      tick(3);
      check_beat("t4_b0", b0, 7, 'h70, 0);
      check_beat("t4_b1", b0 + 1, 8, 'h80, 0);
      check_beat("t4_b2", b0 + 2, 8, 'h81, 1);
      check_beat("t4_b3", b0 + 3, 8, 'h82, 0);
      check_beat("t4_b4", b0 + 4, 8, 'h83, 1);
      if (cap_q.size() - b0 >= 5) begin
         check_eq("t4_to_gap", cap_q[b0+1].cyc - cap_q[b0].cyc, TIMEOUT + 2);
         check_eq("t4_regrant_gap", cap_q[b0+3].cyc - cap_q[b0+2].cyc, 2);
      end
      check_eq("t4_pulses", to_cnt, 1);
      check_eq("t4_mon_id", to_id, 7);
      check_eq("t4_id_held", o_timeout_id, 7);
      check_eq("t4_hold", hold_err, 0);

      // Masked ch4 is never granted; ch6 proceeds.
      b0 = cap_q.size();
      i_enable[4] = 1'b0;
      load(4, 2, 2, 'h40);
      load(6, 2, 2, 'h60);
      wait_beats("t5a_count", b0, 2, 60);
      tick(20);
      check_eq("t5a_no_extra", cap_q.size() - b0, 2);
      check_beat("t5a_b0", b0, 6, 'h60, 0);
      check_beat("t5a_b1", b0 + 1, 6, 'h61, 1);
      check_eq("t5a_ch4_held", bytes_left[4], 2);

      // Enable dropped mid-frame: the ch4 frame still completes.
      b0 = cap_q.size();
      load(4, 4, 4, 'h40);
      i_enable[4] = 1'b1;
      wait_ready("t5b_grant", 4);
      tick(1);
      i_enable[4] = 1'b0;
      wait_beats("t5b_count", b0, 4, 60);
      for (int k = 0; k < 4; k++) check_beat("t5b", b0 + k, 4, 'h40 + k, (k == 3) ? 1 : 0);
      i_enable = '1;
      tick(3);

      // Reset mid-frame on ch9, then ch0 must win over ch5.
      load(9, 6, 6, 'h90);
      w = 0;
      tick(1);
      while (!m_axis_tvalid && w < 40) begin
         tick(1);
         w++;
      end
      check_eq("t5c_midframe", m_axis_tvalid, 1);
      rst = 1'b1;
      bytes_left[9] = 0;
      load(5, 1, 1, 'hB5);
      load(0, 1, 1, 'hB0);
      tick(1);
      check_eq("t5c_tvalid", m_axis_tvalid, 0);
      check_eq("t5c_tdata", m_axis_tdata, 0);
      check_eq("t5c_tlast", m_axis_tlast, 0);
      check_eq("t5c_tid", m_axis_tid, 0);
      check_eq("t5c_s_tready", s_axis_tready, 0);
      check_eq("t5c_timeout", o_timeout, 0);
      check_eq("t5c_timeout_id", o_timeout_id, 0);
      b0 = cap_q.size();
      rst = 1'b0;
      wait_beats("t5c_count", b0, 2, 40);
      check_beat("t5c_b0", b0, 0, 'hB0, 1);
      check_beat("t5c_b1", b0 + 1, 5, 'hB5, 1);
      tick(3);
      check_eq("end_hold", hold_err, 0);
      check_eq("end_stall_tready", stall_err, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
